// File: rtl/mem_access_seq.sv
// Sequences one load/store onto a byte-addressed data cache, splitting misaligned halfword/word accesses into byte ops.
// Response after N+1 (store) or N+2 (load) cycles. req_ready only in IDLE. The response pulse is never stalled.
module mem_access_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_width,
  input  logic [5:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        cache_mode,
  output logic [2:0]  cache_width,
  output logic [5:0]  cache_select,
  output logic [31:0] cache_in,
  input  logic [31:0] cache_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  width_q, width_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        split_q, split_d;
  logic        err_q, err_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req_illegal;
  logic        req_aligned;
  logic [1:0]  req_last;
  logic [31:0] asm_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      width_q <= 3'b000;
      addr_q  <= 6'd0;
      wdata_q <= 32'd0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 2'd0;
      last_q  <= 2'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      width_q <= width_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      split_q <= split_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    width_d = width_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    split_d = split_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    rdata_d = rdata_q;

    req_illegal = (req_width == 3'b011) || (req_width[2:1] == 2'b11) ||
                  (req_we && req_width[2]);
    case (req_width[1:0])
      2'b00:   begin req_aligned = 1'b1;                 req_last = 2'd0; end
      2'b01:   begin req_aligned = ~req_addr[0];         req_last = 2'd1; end
      default: begin req_aligned = (req_addr[1:0] == 2'b00); req_last = 2'd3; end
    endcase

    // Final split-load byte arrives during WAIT, so merge it before extending.
    asm_word = rdata_q;
    asm_word[{cnt_q, 3'b000} +: 8] = cache_out[7:0];

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          width_d = req_width;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = req_illegal;
          split_d = ~req_aligned;
          last_d  = req_aligned ? 2'd0 : req_last;
          cnt_d   = 2'd0;
          rdata_d = 32'd0;
          state_d = req_illegal ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (!we_q && split_q && (cnt_q != 2'd0))
          rdata_d[{cnt_q - 2'd1, 3'b000} +: 8] = cache_out[7:0];
        if (cnt_q == last_q)
          state_d = we_q ? RESP : WAIT;
        else
          cnt_d = cnt_q + 2'd1;
      end
      WAIT: begin
        if (split_q) begin
          case (width_q)
            3'b001:  rdata_d = {{16{asm_word[15]}}, asm_word[15:0]};
            3'b101:  rdata_d = {16'd0, asm_word[15:0]};
            default: rdata_d = asm_word;
          endcase
        end else begin
          rdata_d = cache_out;
        end
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced idle while rst is high so an abandoned op never reaches the cache.
  always_comb begin
    req_ready    = (state_q == IDLE);
    resp_valid   = (state_q == RESP) && !rst;
    resp_err     = resp_valid && err_q;
    resp_rdata   = resp_valid ? rdata_q : 32'd0;
    cache_mode   = 1'b1;
    cache_width  = 3'b010;
    cache_select = 6'd0;
    cache_in     = 32'd0;
    if ((state_q == ISSUE) && !rst) begin
      cache_mode = ~we_q;
      if (split_q) begin
        cache_width  = we_q ? 3'b000 : 3'b100;
        cache_select = addr_q + {4'd0, cnt_q};
        cache_in     = we_q ? {24'd0, wdata_q[{cnt_q, 3'b000} +: 8]} : 32'd0;
      end else begin
        cache_width  = width_q;
        cache_select = addr_q;
        cache_in     = we_q ? wdata_q : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: byte-array cache model plus an independent reference memory.
module tb_mem_access_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_width;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        cache_mode;
  logic [2:0]  cache_width;
  logic [5:0]  cache_select;
  logic [31:0] cache_in;
  logic [31:0] cache_out;

  int tests = 0;
  int fails = 0;

  logic [7:0]  cmem    [64] = '{default: 8'h00};
  logic [7:0]  ref_mem [64] = '{default: 8'h00};
  logic [40:0] wq [$];

  always #5 clk = ~clk;

  mem_access_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_width(req_width), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .cache_mode(cache_mode), .cache_width(cache_width), .cache_select(cache_select),
    .cache_in(cache_in), .cache_out(cache_out)
  );

  function automatic logic [31:0] cread(input logic [2:0] w, input logic [5:0] s);
    logic [31:0] v;
    v = {cmem[6'(s + 6'd3)], cmem[6'(s + 6'd2)], cmem[6'(s + 6'd1)], cmem[s]};
    case (w)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b100:  return {24'd0, v[7:0]};
      3'b101:  return {16'd0, v[15:0]};
      default: return v;
    endcase
  endfunction

  // Data cache: one-cycle read latency, writes on the edge when mode is 0.
  always @(posedge clk) begin
    cache_out <= cread(cache_width, cache_select);
    if (cache_mode == 1'b0) begin
      wq.push_back({cache_width, cache_select, cache_in});
      case (cache_width)
        3'b000: cmem[cache_select] <= cache_in[7:0];
        3'b001: begin
          cmem[cache_select]             <= cache_in[7:0];
          cmem[6'(cache_select + 6'd1)]  <= cache_in[15:8];
        end
        3'b010: begin
          cmem[cache_select]             <= cache_in[7:0];
          cmem[6'(cache_select + 6'd1)]  <= cache_in[15:8];
          cmem[6'(cache_select + 6'd2)]  <= cache_in[23:16];
          cmem[6'(cache_select + 6'd3)]  <= cache_in[31:24];
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_nbytes(input logic [2:0] w);
    case (w[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit ref_illegal(input logic we, input logic [2:0] w);
    return (w == 3'd3) || (w == 3'd6) || (w == 3'd7) || (we && (w == 3'd4 || w == 3'd5));
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] w, input logic [5:0] a);
    int n;
    logic [31:0] v;
    n = ref_nbytes(w);
    v = 32'd0;
    for (int i = 0; i < n; i++)
      v = v | (32'(ref_mem[(int'(a) + i) % 64]) << (8 * i));
    if (n < 4 && !w[2] && v[8 * n - 1])
      v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic run_req(input logic we, input logic [2:0] w, input logic [5:0] a,
                         input logic [31:0] d, output logic [31:0] rd, output int lat);
    logic [40:0] expq [$];
    int n, ops, exp_lat;
    bit ill, al, got;
    logic e;
    logic [31:0] exp_rd;
    ill = ref_illegal(we, w);
    n   = ref_nbytes(w);
    al  = (int'(a) % n) == 0;
    ops = ill ? 0 : (al ? 1 : n);
    exp_lat = ill ? 1 : (we ? ops + 1 : ops + 2);
    exp_rd  = (ill || we) ? 32'd0 : ref_load(w, a);
    if (!ill && we) begin
      if (al) expq.push_back({w, a, d});
      else for (int k = 0; k < n; k++)
        expq.push_back({3'b000, 6'((int'(a) + k) % 64), 24'd0, d[8 * k +: 8]});
    end

    @(negedge clk);
    chk("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_width = w; req_addr = a; req_wdata = d;
    wq.delete();
    @(posedge clk);
    #1;
    // Held-but-unaccepted garbage while busy must have no effect.
    req_we = 1'($urandom); req_width = 3'($urandom); req_addr = 6'($urandom); req_wdata = $urandom;
    got = 0; lat = 0; rd = 32'd0; e = 1'b0;
    for (int c = 1; c <= 16 && !got; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1; lat = c; rd = resp_rdata; e = resp_err;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("resp_seen", got, 1);
    chk("latency", lat, exp_lat);
    chk("resp_err", e, ill);
    chk("resp_rdata", rd, exp_rd);
    @(negedge clk);
    chk("pulse_width", resp_valid, 0);
    chk("ready_after", req_ready, 1);
    chk("wr_op_count", wq.size(), expq.size());
    for (int i = 0; i < wq.size() && i < expq.size(); i++)
      chk("wr_op", wq[i], expq[i]);
    if (!ill && we)
      for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) % 64] = d[8 * i +: 8];
  endtask

  initial begin
    logic [31:0] rd;
    int lat;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_width = 3'b000;
    req_addr = 6'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_cache_mode", cache_mode, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", req_ready, 1);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_resp_err", resp_err, 0);
    chk("reset_resp_rdata", resp_rdata, 0);
    chk("reset_cache_mode", cache_mode, 1);
    chk("reset_cache_width", cache_width, 3'b010);
    chk("reset_cache_select", cache_select, 0);
    chk("reset_cache_in", cache_in, 0);

    // Aligned word store then load.
    run_req(1'b1, 3'b010, 6'd0, 32'h0A0A0A0A, rd, lat);
    chk("sw0_lat", lat, 2);
    chk("sw0_ops", wq.size(), 1);
    run_req(1'b0, 3'b010, 6'd0, 32'h0, rd, lat);
    chk("lw0_data", rd, 32'h0A0A0A0A);
    chk("lw0_lat", lat, 3);

    // Misaligned halfword.
    run_req(1'b1, 3'b001, 6'd5, 32'h000080FF, rd, lat);
    chk("sh5_op0", wq[0], {3'b000, 6'd5, 32'h000000FF});
    chk("sh5_op1", wq[1], {3'b000, 6'd6, 32'h00000080});
    run_req(1'b0, 3'b001, 6'd5, 32'h0, rd, lat);
    chk("lh5_data", rd, 32'hFFFF80FF);
    chk("lh5_lat", lat, 4);
    run_req(1'b0, 3'b101, 6'd5, 32'h0, rd, lat);
    chk("lhu5_data", rd, 32'h000080FF);

    // Word wrapping past address 63.
    run_req(1'b1, 3'b010, 6'd62, 32'h11223344, rd, lat);
    chk("sw62_op2", wq[2], {3'b000, 6'd0, 32'h00000022});
    chk("sw62_op3", wq[3], {3'b000, 6'd1, 32'h00000011});
    run_req(1'b0, 3'b010, 6'd62, 32'h0, rd, lat);
    chk("lw62_data", rd, 32'h11223344);
    chk("lw62_lat", lat, 6);

    // Illegal width.
    run_req(1'b0, 3'b011, 6'd9, 32'h0, rd, lat);
    chk("ill_lat", lat, 1);
    run_req(1'b1, 3'b101, 6'd8, 32'hDEADBEEF, rd, lat);
    chk("ill_store_ops", wq.size(), 0);

    // Reset in the middle of a misaligned word store at address 1.
    run_req(1'b1, 3'b010, 6'd0, 32'h44332211, rd, lat);
    run_req(1'b1, 3'b010, 6'd4, 32'h88776655, rd, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_width = 3'b010; req_addr = 6'd1; req_wdata = 32'hCAFEBEEF;
    wq.delete();
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_cache_mode", cache_mode, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_no_resp", resp_valid, 0);
    chk("midrst_ops", wq.size(), 2);
    ref_mem[1] = 8'hEF;
    ref_mem[2] = 8'hBE;
    run_req(1'b0, 3'b100, 6'd1, 32'h0, rd, lat);
    chk("midrst_b1", rd, 32'h000000EF);
    run_req(1'b0, 3'b100, 6'd2, 32'h0, rd, lat);
    chk("midrst_b2", rd, 32'h000000BE);
    run_req(1'b0, 3'b100, 6'd3, 32'h0, rd, lat);
    chk("midrst_b3", rd, 32'h00000044);
    run_req(1'b0, 3'b100, 6'd4, 32'h0, rd, lat);
    chk("midrst_b4", rd, 32'h00000055);

    // Random traffic against the reference memory.
    for (int i = 0; i < 80; i++)
      run_req(1'($urandom), 3'($urandom), 6'($urandom), $urandom, rd, lat);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_seq.md
MEM_ACCESS_SEQ -- requirements
Module: mem_access_seq

Interface
REQ-001 The block SHALL use one clock and one reset: reset is synchronous and active-high; clock port is clk, reset port is rst.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  clock, rising-edge active
- rst  in  1  synchronous active-high reset
- req_valid  in  1  requester presents an access
- req_ready  out  1  block can accept an access
- req_we  in  1  1 = store, 0 = load
- req_width  in  3  000 sb/lb, 001 sh/lh, 010 sw/lw, 100 lbu, 101 lhu
- req_addr  in  6  byte address
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  illegal request, qualified by resp_valid
- resp_rdata  out  32  load result, extended per req_width
- cache_mode  out  1  data cache mode, 1 = read, 0 = write
- cache_width  out  3  data cache width code
- cache_select  out  6  data cache byte address
- cache_in  out  32  data cache write data
- cache_out  in  32  data cache read data

Function
REQ-003 States SHALL be IDLE, ISSUE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-004 A request SHALL be accepted on the rising edge where req_valid=1 and req_ready=1; all req_* fields SHALL be latched at that edge and ignored afterwards.
REQ-005 An access is aligned when req_width selects a byte, or selects a halfword with addr[0]=0, or selects a word with addr[1:0]=00; otherwise it is misaligned.
REQ-006 An aligned access SHALL be issued as exactly one cache op: cache_width = req_width and cache_select = addr.
REQ-007 A misaligned access SHALL be split into N byte ops (N=2 for a halfword, N=4 for a word):
- op k (k=0..N-1) uses cache_select = (addr+k) mod 64, so addresses wrap from 63 to 0;
- bytes are little-endian.
REQ-008 Read byte ops SHALL use cache_width=100; write byte ops SHALL use cache_width=000 with cache_in[7:0] = wdata byte k.
REQ-009 One cache op SHALL be issued per cycle in ISSUE, in cycles 1..N after acceptance (N=1 when aligned).
REQ-010 cache_mode SHALL be 0 only during a store ISSUE cycle; in every other cycle the outputs SHALL be cache_mode=1, cache_width=010, cache_select=0, cache_in=0.
REQ-011 Cache read latency is one cycle: cache_out for the op issued in cycle k SHALL be sampled at the end of cycle k+1.
REQ-012 Load sequence: ISSUE for N cycles, then WAIT for 1 cycle, then RESP; resp_valid SHALL be high in cycle N+2 after acceptance.
REQ-013 Store sequence: ISSUE for N cycles, then RESP; resp_valid SHALL be high in cycle N+1 after acceptance.
REQ-014 For a split load, the assembled value SHALL be extended per req_width:
- 001 and 010 sign-extend;
- 101 zero-extends.
For an aligned load, resp_rdata SHALL equal cache_out unmodified.
REQ-015 For a store, resp_rdata SHALL be 0.
REQ-016 Illegal requests are width 011, 110 or 111, and stores with width 100 or 101. For these the block SHALL issue no cache op and SHALL go directly to RESP in cycle 1 with resp_err=1 and resp_rdata=0.
REQ-017 resp_valid SHALL be a single-cycle pulse; RESP SHALL return to IDLE unconditionally, with no backpressure on the response.
REQ-018 A request with req_valid=1 arriving while req_ready=0 SHALL NOT be accepted; the requester holds it until accepted.

Reset
REQ-019 While rst=1 at a rising edge, the block SHALL go to IDLE and drive:
- req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0;
- cache outputs at the idle values of REQ-010.
REQ-020 A reset asserted mid-sequence SHALL abandon the remaining byte ops with no response; bytes already written SHALL remain in the cache.

Verification
REQ-021 Aligned sw of 0x0A0A0A0A at addr 0, then lw at addr 0:
- store: one cycle with cache_mode=0, resp_valid in cycle 2;
- load: resp_rdata=0x0A0A0A0A in cycle 3.
REQ-022 sh of 0x0000_80FF at addr 5:
- two sb ops, to select 5 (data 0xFF) then select 6 (data 0x80);
- lh at addr 5 then returns 0xFFFF80FF in cycle 4;
- lhu at addr 5 returns 0x000080FF.
REQ-023 sw of 0x11223344 at addr 62:
- byte ops go to selects 62, 63, 0, 1 with data 44, 33, 22, 11;
- lw at addr 62 returns 0x11223344 in cycle 6.
REQ-024 Request with width 011 -> no cycle with cache_mode=0; resp_valid=1 and resp_err=1 in cycle 1; req_ready=1 in the following cycle.
REQ-025 Misaligned sw at addr 1 with rst=1 in cycle 3:
- selects 1 and 2 are written;
- no response pulse;
- req_ready=1 in the next cycle;
- selects 3 and 4 keep their old contents.
